// File: rtl/pb_sample_fetcher.sv
// pb_sample_fetcher
//   Playback sample fetch engine. A go pulse latches a start address and a
//   sample count. After that, each sample_tick issues one read to a
//   synchronous sample RAM. The returned sample is offered to the DAC
//   serialiser over a valid/ready handshake. Status bits busy, done and
//   overrun are provided for the CPU.
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   pb_adr, pb_len      job start address / sample count (sampled at go)
//   go                  1-cycle job start pulse
//   sample_tick         1-cycle sample-rate strobe
//   mem_addr, mem_rd    RAM read address / 1-cycle read strobe
//   mem_rdata           RAM data, valid RD_LATENCY cycles after mem_rd
//   sample_out/valid    sample to DAC, held until sample_ready
//   sample_ready        DAC accepts sample
//   busy, done, overrun status (done and overrun are sticky until next go)
// RD_LATENCY must lie in 1..3.
module pb_sample_fetcher #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pb_adr,
    input  logic [ADDR_W-1:0] pb_len,
    input  logic              go,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT_TICK, READ, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [LAT_W-1:0]  lat_cnt;

    assign mem_addr = cur_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            lat_cnt      <= '0;
            mem_rd       <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick that coincides with go is ignored here, so it
                    // can never be counted as an overrun.
                    if (go) begin
                        cur_addr  <= pb_adr;
                        remaining <= pb_len;
                        overrun   <= 1'b0;
                        if (pb_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            state <= WAIT_TICK;
                        end
                    end
                end
                WAIT_TICK: begin
                    if (sample_tick) begin
                        mem_rd  <= 1'b1;
                        lat_cnt <= '0;
                        state   <= READ;
                    end
                end
                READ: begin
                    // lat_cnt counts the edges since the one that sampled
                    // mem_rd. Data is captured on the edge where the count
                    // equals RD_LATENCY.
                    mem_rd <= 1'b0;
                    if (sample_tick)
                        overrun <= 1'b1;
                    if (lat_cnt == LAT_W'(RD_LATENCY)) begin
                        sample_out   <= mem_rdata;
                        sample_valid <= 1'b1;
                        lat_cnt      <= '0;
                        state        <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                HOLD: begin
                    // A tick is dropped even in the handshake cycle, because
                    // WAIT_TICK is only reached on the following cycle.
                    if (sample_tick)
                        overrun <= 1'b1;
                    if (sample_valid && sample_ready) begin
                        sample_valid <= 1'b0;
                        cur_addr     <= cur_addr + ADDR_W'(1);
                        remaining    <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= WAIT_TICK;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
